// File: rtl/sum_accumulator_if.sv
// Handshake bundle between an upstream adder, the sum_accumulator and its consumer.
// The master side drives samples and out_ready; the slave side is the accumulator.
interface sum_accumulator_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [7:0]       out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );
endinterface

// File: rtl/sum_accumulator.sv
// Sums COUNT unsigned samples (or fewer on flush) and holds the result until taken.
// Optional macro ACC_SAT_EN: clamp the sum to all-ones on carry instead of wrapping.
module sum_accumulator #(
  parameter int WIDTH = 32,
  parameter int COUNT = 4
) (
  input logic           clk,
  input logic           rst,
  sum_accumulator_if.slave bus
);

  if (COUNT < 2 || COUNT > 255) begin : g_count_check
    $error("sum_accumulator: COUNT must be within 2..255");
  end

  localparam logic [7:0] COUNT_C = COUNT[7:0];

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [7:0]       cnt;
  logic             ovf;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [WIDTH:0]   sum;
  logic             carry;
  logic             accept;
  logic [WIDTH-1:0] acc_add;
  logic [7:0]       cnt_inc;
  logic             to_hold;

  always_comb begin
    sum     = {1'b0, acc} + {1'b0, bus.in_data};
    carry   = sum[WIDTH];
`ifdef ACC_SAT_EN
    // Once clamped, the result stays at all-ones even if later adds do not carry.
    acc_add = (carry || ovf) ? '1 : sum[WIDTH-1:0];
`else
    acc_add = sum[WIDTH-1:0];
`endif
    cnt_inc = cnt + 8'd1;
    accept  = bus.in_valid & in_ready_q;
    // A flush with nothing collected and no sample arriving has nothing to emit.
    to_hold = (accept && (cnt_inc == COUNT_C)) ||
              (bus.flush && (accept || (cnt != 8'd0)));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACCUM;
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc <= acc_add;
            cnt <= cnt_inc;
            ovf <= ovf | carry;
          end
          if (to_hold) begin
            state       <= HOLD;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= ACCUM;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc;
  assign bus.out_count = cnt;
  assign bus.out_ovf   = ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator (WIDTH=32, COUNT=4): a vector table plus
// hand-written sequences for back-pressure and reset-discard behaviour.
module tb_sum_accumulator;

  localparam int WIDTH = 32;
  localparam int COUNT = 4;

`ifdef ACC_SAT_EN
  localparam logic [31:0] OVF_DATA = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] OVF_DATA = 32'h0000_0010;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sum_accumulator_if #(.WIDTH(WIDTH)) bus ();

  sum_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        fl;
    logic        ordy;
    logic        ir;
    logic        ov;
    logic [31:0] data;
    logic [7:0]  cnt;
    logic        ovf;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outputs are read 1 time unit after the rising edge, once flops have settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic fl, input logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.flush     = fl;
    bus.out_ready = ordy;
  endtask

  task automatic check_all(input string tag, input logic ir, input logic ov,
                           input logic [31:0] data, input logic [7:0] cnt, input logic ovf);
    check({tag, ".in_ready"},  bus.in_ready,  ir);
    check({tag, ".out_valid"}, bus.out_valid, ov);
    check({tag, ".out_data"},  bus.out_data,  data);
    check({tag, ".out_count"}, bus.out_count, cnt);
    check({tag, ".out_ovf"},   bus.out_ovf,   ovf);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 32'd999, 1'b1, 1'b0);  // reset must win over all other inputs
    step();
    step();
    check_all("reset", 1'b1, 1'b0, 32'd0, 8'd0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0);

    //          iv  d             fl ordy  ir ov data          cnt ovf
    // Four-sample result, taken immediately.
    vq.push_back('{1, 32'd1926,     0, 1,   1, 0, 32'd1926,     1, 0});
    vq.push_back('{1, 32'd817,      0, 1,   1, 0, 32'd2743,     2, 0});
    vq.push_back('{1, 32'd0,        0, 1,   1, 0, 32'd2743,     3, 0});
    vq.push_back('{1, 32'd5,        0, 1,   0, 1, 32'd2748,     4, 0});
    vq.push_back('{0, 32'd0,        0, 1,   1, 0, 32'd0,        0, 0});
    // Flush with a concurrent sample includes that sample.
    vq.push_back('{1, 32'd10,       0, 1,   1, 0, 32'd10,       1, 0});
    vq.push_back('{1, 32'd20,       0, 1,   1, 0, 32'd30,       2, 0});
    vq.push_back('{1, 32'd7,        1, 1,   0, 1, 32'd37,       3, 0});
    vq.push_back('{0, 32'd0,        0, 1,   1, 0, 32'd0,        0, 0});
    // Flush on an empty accumulator does nothing.
    vq.push_back('{0, 32'd0,        1, 1,   1, 0, 32'd0,        0, 0});
    vq.push_back('{0, 32'd0,        1, 0,   1, 0, 32'd0,        0, 0});
    // Carry out of 32 bits, then flush; flush in HOLD is ignored.
    vq.push_back('{1, 32'hFFFFFFF0, 0, 0,   1, 0, 32'hFFFFFFF0, 1, 0});
    vq.push_back('{1, 32'h20,       0, 0,   1, 0, OVF_DATA,     2, 1});
    vq.push_back('{0, 32'd0,        1, 0,   0, 1, OVF_DATA,     2, 1});
    vq.push_back('{0, 32'd0,        0, 0,   0, 1, OVF_DATA,     2, 1});
    vq.push_back('{0, 32'd0,        1, 0,   0, 1, OVF_DATA,     2, 1});
    vq.push_back('{0, 32'd0,        0, 1,   1, 0, 32'd0,        0, 0});

    do_reset();

    foreach (vq[i]) begin
      drive(vq[i].iv, vq[i].d, vq[i].fl, vq[i].ordy);
      step();
      check_all($sformatf("vec%0d", i), vq[i].ir, vq[i].ov, vq[i].data, vq[i].cnt, vq[i].ovf);
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0);

    // Back-pressure: result held while upstream keeps offering a sample.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b0);
      step();
    end
    check_all("bp.hold", 1'b0, 1'b1, 32'd10, 8'd4, 1'b0);
    drive(1'b1, 32'd100, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_all($sformatf("bp.stall%0d", i), 1'b0, 1'b1, 32'd10, 8'd4, 1'b0);
    end
    bus.out_ready = 1'b1;
    step();
    check_all("bp.release", 1'b1, 1'b0, 32'd0, 8'd0, 1'b0);
    step();
    check_all("bp.kept", 1'b1, 1'b0, 32'd100, 8'd1, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    step();
    check_all("bp.flush", 1'b0, 1'b1, 32'd100, 8'd1, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    step();
    check_all("bp.done", 1'b1, 1'b0, 32'd0, 8'd0, 1'b0);

    // Reset in HOLD discards the result.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'd1, 1'b0, 1'b0);
      step();
    end
    check_all("rst.hold_pre", 1'b0, 1'b1, 32'd4, 8'd4, 1'b0);
    do_reset();

    // Reset mid-accumulation discards partial samples.
    drive(1'b1, 32'd50, 1'b0, 1'b1);
    step();
    drive(1'b1, 32'd60, 1'b0, 1'b1);
    step();
    check_all("rst.mid_pre", 1'b1, 1'b0, 32'd110, 8'd2, 1'b0);
    do_reset();

    for (int i = 3; i <= 6; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b1);
      step();
    end
    check_all("rst.post", 1'b0, 1'b1, 32'd18, 8'd4, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    step();
    check_all("rst.post_done", 1'b1, 1'b0, 32'd0, 8'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width of in_data and out_data.
REQ-002 The block SHALL have parameter COUNT, default 4, giving the samples per result; legal range 2..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream adder result valid.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: unsigned sum from the upstream adder's out.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 The block SHALL have port flush, input, 1 bit: force emission of a partial result.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a result is held on the out_* ports.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumer takes the result.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: the accumulated sum.
REQ-012 The block SHALL have port out_count, output, 8 bits: the number of samples in out_data.
REQ-013 The block SHALL have port out_ovf, output, 1 bit: a carry out of WIDTH bits occurred during this result.

Function
REQ-014 The block SHALL implement two states, ACCUM and HOLD; in_ready = 1 in ACCUM and 0 in HOLD; out_valid = 1 only in HOLD.
REQ-015 In ACCUM, an accept (in_valid & in_ready) SHALL add in_data to acc, increment cnt, and OR the carry out into ovf, all registered on the same edge.
REQ-016 An accept that makes cnt equal COUNT SHALL move the block to HOLD; out_valid SHALL rise on the edge of that accept (1-cycle latency from the last sample).
REQ-017 flush in ACCUM with cnt > 0 or a concurrent accept SHALL move the block to HOLD; a concurrent sample SHALL be included in the result.
REQ-018 flush in ACCUM with cnt = 0 and no accept SHALL be ignored.
REQ-019 flush in HOLD SHALL be ignored.
REQ-020 In HOLD, out_data, out_count and out_ovf SHALL stay stable until out_valid & out_ready.
REQ-021 On out_valid & out_ready the block SHALL clear acc, cnt and ovf and return to ACCUM; in_ready SHALL be 1 on the next cycle, so there is no bubble beyond one cycle.
REQ-022 in_valid asserted while the block is in HOLD SHALL NOT be consumed; upstream SHALL hold its data.
REQ-023 Arithmetic SHALL be unsigned, WIDTH-bit, using a WIDTH+1-bit internal add for carry detection.

Reset
REQ-024 rst = 1 at a clock edge SHALL set state = ACCUM, acc = 0, cnt = 0 and ovf = 0.
REQ-025 While in reset, outputs SHALL read out_valid = 0, in_ready = 1 (after the first edge), out_data = 0, out_count = 0, out_ovf = 0.
REQ-026 rst asserted mid-accumulation or in HOLD SHALL discard the pending result with no emission.
REQ-027 rst SHALL take priority over every other input.

Configuration
REQ-028 With macro ACC_SAT_EN defined, an add that carries out SHALL clamp acc to all-ones, stay clamped for the rest of that result, and set out_ovf.
REQ-029 Without ACC_SAT_EN, acc SHALL wrap modulo 2^WIDTH, and out_ovf SHALL be sticky for that result.

Verification
REQ-030 The bench SHALL cover this scenario: COUNT=4, accepts of 1926, 817, 0, 5 with out_ready=1 -> out_valid for exactly one cycle, out_data=2748, out_count=4, out_ovf=0, then in_ready=1.
REQ-031 The bench SHALL cover this scenario: out_ready=0 after 4 accepts, in_valid held at 1 for 5 cycles -> in_ready=0, out_data stable at its value, and no sample lost once out_ready rises.
REQ-032 The bench SHALL cover this scenario: 2 accepts (10, 20), then flush with in_valid=1 and in_data=7 -> out_data=37, out_count=3.
REQ-033 The bench SHALL cover this scenario: flush with cnt=0 and in_valid=0 -> out_valid stays 0.
REQ-034 The bench SHALL cover this scenario: accepts of 32'hFFFFFFF0 then 32'h20 and then flush -> out_ovf=1; out_data=32'h10 without ACC_SAT_EN and 32'hFFFFFFFF with it.
REQ-035 The bench SHALL cover this scenario: rst pulsed in HOLD and after 2 accepts -> out_valid=0, and the next result counts only post-reset samples.
